// File: rtl/branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_btb
// Purpose  : Direct-mapped BTB with saturating direction counters for IF-stage
//            next-PC prediction, EX-stage resolution with redirect, table
//            training, and saturating branch / mispredict performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_btb #(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // Fetch-side lookup
  input  logic [PC_W-1:0]   if_pc_i,
  output logic              pred_taken_o,
  output logic [PC_W-1:0]   pred_target_o,
  // Execute-side resolution
  input  logic              ex_valid_i,
  input  logic [PC_W-1:0]   ex_pc_i,
  input  logic [1:0]        ex_kind_i,
  input  logic              ex_taken_i,
  input  logic [PC_W-1:0]   ex_target_i,
  input  logic              ex_pred_taken_i,
  input  logic [PC_W-1:0]   ex_pred_target_i,
  output logic              redirect_o,
  output logic [PC_W-1:0]   redirect_pc_o,
  // Performance counters
  output logic [PERF_W-1:0] perf_branches_o,
  output logic [PERF_W-1:0] perf_mispred_o
);

  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int TAG_LO  = IDX_W + 2;
  // Tag storage keeps at least one bit so the arrays stay legal; when the PC
  // has no bits above the index that bit is tied to zero and always matches.
  localparam int TAG_W   = (PC_W > TAG_LO) ? (PC_W - TAG_LO) : 1;

  localparam logic [PC_W-1:0]  PC_FOUR  = PC_W'(4);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

  localparam logic [1:0] KIND_B    = 2'b00;
  localparam logic [1:0] KIND_JAL  = 2'b01;
  localparam logic [1:0] KIND_JALR = 2'b10;
  localparam logic [1:0] KIND_RSVD = 2'b11;

  // --------------------------------------------------------------------------
  // Table storage
  // --------------------------------------------------------------------------
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];
  logic             jump_q   [ENTRIES];

  logic [PERF_W-1:0] perf_br_q, perf_br_d;
  logic [PERF_W-1:0] perf_mp_q, perf_mp_d;

  // --------------------------------------------------------------------------
  // Address split
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] if_tag;
  logic [TAG_W-1:0] ex_tag;

  assign if_idx = if_pc_i[IDX_W+1:2];
  assign ex_idx = ex_pc_i[IDX_W+1:2];

  generate
    if (PC_W > TAG_LO) begin : g_tag
      assign if_tag = if_pc_i[PC_W-1:TAG_LO];
      assign ex_tag = ex_pc_i[PC_W-1:TAG_LO];
    end else begin : g_notag
      assign if_tag = '0;
      assign ex_tag = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Prediction: pure read of the current table, no bypass from training
  // --------------------------------------------------------------------------
  logic            if_hit;
  logic [PC_W-1:0] if_seq_pc;

  assign if_seq_pc = if_pc_i + PC_FOUR;

  // Lookup for the fetch PC
  always_comb begin
    if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken_o  = if_hit && (jump_q[if_idx] || cnt_q[if_idx][CNT_W-1]);
    pred_target_o = pred_taken_o ? target_q[if_idx] : if_seq_pc;
  end

  // --------------------------------------------------------------------------
  // Resolution
  // --------------------------------------------------------------------------
  logic            ex_ok;
  logic            ex_is_jump;
  logic            actual_taken;
  logic            mispredict;
  logic [PC_W-1:0] ex_seq_pc;

  assign ex_seq_pc = ex_pc_i + PC_FOUR;

  // Compare resolved outcome with the prediction carried from fetch
  always_comb begin
    ex_ok         = ex_valid_i && (ex_kind_i != KIND_RSVD);
    ex_is_jump    = (ex_kind_i == KIND_JAL) || (ex_kind_i == KIND_JALR);
    actual_taken  = ex_taken_i || ex_is_jump;
    mispredict    = ex_ok &&
                    ((actual_taken != ex_pred_taken_i) ||
                     (actual_taken && (ex_target_i != ex_pred_target_i)));
    // Redirect is held low while the core is in reset
    redirect_o    = mispredict && rst_ni;
    redirect_pc_o = actual_taken ? ex_target_i : ex_seq_pc;
  end

  // --------------------------------------------------------------------------
  // Training: compute the new contents of the single entry addressed by EX
  // --------------------------------------------------------------------------
  logic             ex_hit;
  logic             ent_we;
  logic [TAG_W-1:0] ent_tag_d;
  logic [PC_W-1:0]  ent_tgt_d;
  logic [CNT_W-1:0] ent_cnt_d;
  logic             ent_jump_d;
  logic [CNT_W-1:0] ex_cnt;

  // Next-state for the trained entry
  always_comb begin
    ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_cnt     = cnt_q[ex_idx];
    ent_we     = 1'b0;
    ent_tag_d  = tag_q[ex_idx];
    ent_tgt_d  = target_q[ex_idx];
    ent_cnt_d  = ex_cnt;
    ent_jump_d = jump_q[ex_idx];
    if (ex_ok) begin
      if (ex_hit) begin
        ent_we = 1'b1;
        if (ex_kind_i == KIND_B) begin
          if (ex_taken_i) begin
            ent_cnt_d = (ex_cnt != CNT_MAX) ? ex_cnt + CNT_W'(1) : ex_cnt;
            ent_tgt_d = ex_target_i;
          end else begin
            ent_cnt_d = (ex_cnt != '0) ? ex_cnt - CNT_W'(1) : ex_cnt;
          end
        end else begin
          ent_tgt_d = ex_target_i;
        end
      end else if (actual_taken) begin
        // Allocate over whatever lived at this index
        ent_we     = 1'b1;
        ent_tag_d  = ex_tag;
        ent_tgt_d  = ex_target_i;
        ent_cnt_d  = CNT_WEAK;
        ent_jump_d = ex_is_jump;
      end
    end
  end

  // Table update; reset clears every entry and drops any pending write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
        jump_q[i]   <= 1'b0;
      end
    end else if (ent_we) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= ent_tag_d;
      target_q[ex_idx] <= ent_tgt_d;
      cnt_q[ex_idx]    <= ent_cnt_d;
      jump_q[ex_idx]   <= ent_jump_d;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters, saturating at all-ones
  // --------------------------------------------------------------------------
  // Next-state for the performance counters
  always_comb begin
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (ex_ok && (perf_br_q != {PERF_W{1'b1}})) begin
      perf_br_d = perf_br_q + PERF_W'(1);
    end
    if (mispredict && (perf_mp_q != {PERF_W{1'b1}})) begin
      perf_mp_d = perf_mp_q + PERF_W'(1);
    end
  end

  // Performance counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign perf_branches_o = perf_br_q;
  assign perf_mispred_o  = perf_mp_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_btb.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_btb
// Purpose  : Scoreboard bench for branch_predictor_btb with a behavioural
//            table model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_btb;

  localparam int PC_W    = 9;
  localparam int ENTRIES = 16;
  localparam int CNT_W   = 2;
  localparam int PERF_W  = 16;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int IDX_W   = 4;
  localparam int CNT_TOP = (1 << CNT_W) - 1;
  localparam int CNT_THR = 1 << (CNT_W - 1);
  localparam int PERF_TOP = (1 << PERF_W) - 1;

  logic              clk;
  logic              rst_n;
  logic [PC_W-1:0]   if_pc;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic              ex_valid;
  logic [PC_W-1:0]   ex_pc;
  logic [1:0]        ex_kind;
  logic              ex_taken;
  logic [PC_W-1:0]   ex_target;
  logic              ex_pred_taken;
  logic [PC_W-1:0]   ex_pred_target;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic [PERF_W-1:0] perf_branches;
  logic [PERF_W-1:0] perf_mispred;

  branch_predictor_btb #(
    .PC_W(PC_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .PERF_W(PERF_W)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .if_pc_i          (if_pc),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .ex_valid_i       (ex_valid),
    .ex_pc_i          (ex_pc),
    .ex_kind_i        (ex_kind),
    .ex_taken_i       (ex_taken),
    .ex_target_i      (ex_target),
    .ex_pred_taken_i  (ex_pred_taken),
    .ex_pred_target_i (ex_pred_target),
    .redirect_o       (redirect),
    .redirect_pc_o    (redirect_pc),
    .perf_branches_o  (perf_branches),
    .perf_mispred_o   (perf_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: a map from index to the entry a PC would occupy
  // --------------------------------------------------------------------------
  bit m_valid [ENTRIES];
  int m_tag   [ENTRIES];
  int m_tgt   [ENTRIES];
  int m_cnt   [ENTRIES];
  bit m_jump  [ENTRIES];
  int m_br;
  int m_mp;

  typedef struct {
    int pt;
    int ptgt;
    int rd;
    int rpc;
    int pb;
    int pm;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic int idx_of(int pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int tag_of(int pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(int pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 0; m_jump[i] = 0;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic model_predict(input int pc, output int t, output int tgt);
    int i;
    i = idx_of(pc);
    t = (m_hit(pc) && (m_jump[i] || m_cnt[i] >= CNT_THR)) ? 1 : 0;
    tgt = t ? m_tgt[i] : (pc + 4) % PC_MOD;
  endtask

  task automatic model_train(input int v, input int kind, input int pc,
                             input int taken, input int tgt, input int rd);
    int i;
    int act;
    i = idx_of(pc);
    act = (taken != 0 || kind == 1 || kind == 2) ? 1 : 0;
    if (v == 0) return;
    if (m_br < PERF_TOP) m_br++;
    if (rd != 0 && m_mp < PERF_TOP) m_mp++;
    if (m_hit(pc)) begin
      if (kind == 0) begin
        if (taken != 0) begin
          if (m_cnt[i] < CNT_TOP) m_cnt[i]++;
          m_tgt[i] = tgt;
        end else if (m_cnt[i] > 0) begin
          m_cnt[i]--;
        end
      end else begin
        m_tgt[i] = tgt;
      end
    end else if (act != 0) begin
      m_valid[i] = 1; m_tag[i] = tag_of(pc); m_tgt[i] = tgt;
      m_cnt[i] = CNT_THR; m_jump[i] = (kind != 0);
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver: apply one cycle of stimulus, push expectation, train the model
  // --------------------------------------------------------------------------
  task automatic step(input int ipc, input int v, input int kind, input int pc,
                      input int taken, input int tgt, input int ptk, input int ptgt);
    exp_t e;
    int vv, act;
    if_pc = PC_W'(ipc);
    ex_valid = v[0]; ex_pc = PC_W'(pc); ex_kind = kind[1:0]; ex_taken = taken[0];
    ex_target = PC_W'(tgt); ex_pred_taken = ptk[0]; ex_pred_target = PC_W'(ptgt);
    model_predict(ipc, e.pt, e.ptgt);
    vv  = (v != 0 && kind != 3) ? 1 : 0;
    act = (taken != 0 || kind == 1 || kind == 2) ? 1 : 0;
    e.rd  = (vv != 0 && (act != ptk || (act != 0 && tgt != ptgt))) ? 1 : 0;
    e.rpc = act ? tgt : (pc + 4) % PC_MOD;
    e.pb  = m_br;
    e.pm  = m_mp;
    sb.push_back(e);
    @(posedge clk);
    model_train(vv, kind, pc, taken, tgt, e.rd);
    #1;
  endtask

  task automatic idle(input int ipc);
    step(ipc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Resolve with the prediction the model would have given at fetch
  task automatic resolve(input int kind, input int pc, input int taken, input int tgt);
    int pt, ptg;
    model_predict(pc, pt, ptg);
    step(pc, 1, kind, pc, taken, tgt, pt, ptg);
  endtask

  // Assert reset while a training write is pending, then release cleanly
  task automatic reset_mid(input int pc, input int tgt);
    exp_t e;
    if_pc = PC_W'(pc);
    ex_valid = 1'b1; ex_pc = PC_W'(pc); ex_kind = 2'b01; ex_taken = 1'b1;
    ex_target = PC_W'(tgt); ex_pred_taken = 1'b0; ex_pred_target = '0;
    #1 rst_n = 1'b0;
    model_reset();
    e.pt = 0; e.ptgt = (pc + 4) % PC_MOD; e.rd = 0; e.rpc = 0; e.pb = 0; e.pm = 0;
    sb.push_back(e);
    @(posedge clk);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  function automatic int rand_pc();
    int sel;
    sel = $urandom_range(0, 5);
    case (sel)
      0: return 'h040;
      1: return 'h0C0;
      2: return 'h010;
      3: return 'h1FC;
      default: return int'($urandom % PC_MOD) & ~3;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Monitor: compare every presented cycle against the queued expectation
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pred_taken",    int'(pred_taken),    e.pt);
      chk("pred_target",   int'(pred_target),   e.ptgt);
      chk("redirect",      int'(redirect),      e.rd);
      if (e.rd != 0) chk("redirect_pc", int'(redirect_pc), e.rpc);
      chk("perf_branches", int'(perf_branches), e.pb);
      chk("perf_mispred",  int'(perf_mispred),  e.pm);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    if_pc = '0; ex_valid = 1'b0; ex_pc = '0; ex_kind = '0; ex_taken = 1'b0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Cold start
    idle('h040);
    // Train and hit, then hysteresis
    step('h040, 1, 0, 'h040, 1, 'h020, 0, 'h044);
    step('h040, 1, 0, 'h040, 0, 'h000, 1, 'h020);
    idle('h040);
    resolve(0, 'h040, 1, 'h020);
    resolve(0, 'h040, 1, 'h020);
    resolve(0, 'h040, 0, 'h000);
    idle('h040);
    // Alias and replacement by a jump
    idle('h0C0);
    step('h0C0, 1, 1, 'h0C0, 0, 'h100, 0, 'h0C4);
    idle('h040);
    idle('h0C0);
    // JALR target change
    step('h010, 1, 2, 'h010, 0, 'h080, 0, 'h014);
    step('h010, 1, 2, 'h010, 1, 'h0A0, 1, 'h080);
    idle('h010);
    // Wrap at the top of the PC space
    step('h1FC, 1, 0, 'h1FC, 0, 'h000, 1, 'h040);
    idle('h1FC);
    // Reserved kind behaves as no instruction
    step('h040, 1, 3, 'h040, 1, 'h0A0, 0, 'h044);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int pc, pt, ptg, kind;
      pc = rand_pc();
      kind = $urandom_range(0, 3);
      model_predict(pc, pt, ptg);
      if ($urandom_range(0, 3) == 0) begin
        pt = $urandom_range(0, 1);
        ptg = int'($urandom % PC_MOD) & ~3;
      end
      step(rand_pc(), ($urandom_range(0, 3) != 0) ? 1 : 0, kind, pc,
           $urandom_range(0, 1), int'($urandom % PC_MOD) & ~3, pt, ptg);
    end

    // Drive both perf counters into saturation
    for (int n = 0; n < PERF_TOP + 5; n++) begin
      step('h088, 1, 0, 'h188, 0, 0, 1, 'h020);
    end

    // Reset during a pending allocation, then verify the table is empty
    reset_mid('h050, 'h0F0);
    idle('h050);
    idle('h040);
    idle('h0C0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised successor to the EX-stage branch resolver: dynamic prediction plus resolution for the 5-stage RISC-V pipeline.
- IF side: a direct-mapped branch target buffer (BTB) with per-entry saturating counters supplies the predicted next PC each cycle.
- EX side: compares the resolved outcome (taken/target for B-type, JAL, JALR) against the prediction carried down the pipe, then raises redirect/flush and trains the tables.
- Keeps saturating performance counters.

Parameters:
- PC_W, 9, PC width in bits; PCs are word aligned.
- ENTRIES, 16, BTB entries; power of two, >=2; IDX_W = log2(ENTRIES).
- CNT_W, 2, saturating direction counter width, >=1.
- PERF_W, 16, width of the performance counters.

Ports:
- clk  input  1  pipeline clock, all state rises on posedge.
- reset  input  1  asynchronous, active-low reset.
- if_pc  input  PC_W  fetch PC this cycle.
- pred_taken  output  1  combinational: BTB predicts a redirect for if_pc.
- pred_target  output  PC_W  combinational: predicted next PC; if_pc+4 (mod 2^PC_W) when pred_taken=0.
- ex_valid  input  1  EX holds a valid control-flow instruction this cycle.
- ex_pc  input  PC_W  PC of that instruction.
- ex_kind  input  2  00 = B-type, 01 = JAL, 10 = JALR, 11 = reserved (treated as ex_valid=0).
- ex_taken  input  1  resolved direction; ignored and forced 1 for JAL/JALR.
- ex_target  input  PC_W  resolved target, bit0 already cleared.
- ex_pred_taken  input  1  pred_taken that was sampled at fetch for this instruction.
- ex_pred_target  input  PC_W  pred_target that was sampled at fetch for this instruction.
- redirect  output  1  combinational: mispredict, flush IF/ID and load redirect_pc.
- redirect_pc  output  PC_W  correct next PC: ex_target if taken, else ex_pc+4.
- perf_branches  output  PERF_W  resolved control-flow instructions, saturating.
- perf_mispred  output  PERF_W  mispredicts, saturating.

Behaviour:
- Addressing: idx = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. If IDX_W+2 >= PC_W, tag is empty and every valid hit matches.
- Entry fields: valid, tag, target[PC_W], cnt[CNT_W], is_jump (JAL/JALR).
- Predict (combinational, zero latency):
  - hit = valid && tag match.
  - pred_taken = hit && (is_jump || cnt MSB).
  - pred_target = entry target when pred_taken, else if_pc+4 truncated to PC_W.
- Resolve (combinational on ex_*):
  - actual_taken = ex_taken, or 1 for JAL/JALR.
  - redirect = ex_valid && (actual_taken != ex_pred_taken || (actual_taken && ex_target != ex_pred_target)).
  - redirect_pc = actual_taken ? ex_target : ex_pc+4.
  - redirect = 0 whenever ex_valid = 0.
- Train (registered, visible to if_pc the cycle after the posedge where ex_valid=1):
  - Hit, B-type: cnt increments on taken, decrements on not-taken, saturating at 0 and 2^CNT_W-1; target <= ex_target on taken.
  - Hit, JAL/JALR: target <= ex_target; cnt untouched.
  - Miss with actual_taken=1: allocate/replace the entry; valid=1, tag, target=ex_target, is_jump per kind, cnt = 2^(CNT_W-1) (weakly taken).
  - Miss with not-taken: no allocation, no state change.
- Same-cycle read/write to the same index: prediction uses pre-update contents; no bypass.
- Perf counters:
  - perf_branches +1 per ex_valid cycle.
  - perf_mispred +1 per redirect cycle.
  - Both hold at all-ones.
- Reset (asynchronous assertion, synchronous release):
  - All valid=0, cnt=0, targets=0, perf counters=0.
  - pred_taken=0, pred_target=if_pc+4, redirect=0.
  - Reset asserted mid-training: the pending update is discarded.
- Arithmetic: all PC adds wrap modulo 2^PC_W (PC_W=9: 0x1FC+4 = 0x000).

Test Plan:
- Cold start: reset, release, if_pc=0x040 -> pred_taken=0, pred_target=0x044; perf counters 0.
- Train and hit: B-type at 0x040, ex_taken=1, ex_target=0x020, ex_pred_taken=0.
  - Required: redirect=1, redirect_pc=0x020; next cycle if_pc=0x040 -> pred_taken=1, pred_target=0x020 (cnt=2).
- Hysteresis: same branch resolves not-taken once.
  - Required: redirect=1, redirect_pc=0x044; cnt=1 -> pred_taken=0.
  - Two further taken resolutions -> cnt=3; one not-taken still predicts taken.
- Alias/tag: after the 0x040 entry is trained, if_pc=0x0C0 (same idx 0, different tag) -> pred_taken=0.
  - JAL at 0x0C0 to 0x100 replaces the entry; 0x040 then misses.
- JALR target change: JALR at 0x010 trained to 0x080, then resolves to 0x0A0 with ex_pred_target=0x080.
  - Required: redirect=1, redirect_pc=0x0A0; entry target becomes 0x0A0.
- Wrap/saturation/reset: not-taken at 0x1FC -> redirect_pc=0x000. Force perf_mispred to 0xFFFF via 65535 mispredicts; one more stays 0xFFFF. Assert reset mid-update -> all counters 0, no hits.
